// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction words over a req/ack handshake,
// and presents them to decode. One skid entry absorbs a word that returns while
// decode is stalled; a redirect flushes everything fetched so far.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_n;
  logic [31:0] req_addr_q, req_addr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_pc4_q, out_pc4_d;

  // Redirect target is always word aligned; low bits are simply dropped.
  logic [31:0] redir_pc;
  logic [31:0] req_addr_plus4;
  logic        out_free;
  logic        accept_out;
  logic        accept_skid;

  assign redir_pc       = redirect_pc & ~32'h3;
  assign req_addr_plus4 = req_addr_q + 32'd4;
  assign out_free       = !out_valid_q || !stall_d;

  // Request is driven straight from registered state so it never glitches.
  assign imem_req   = (state_q == REQ) || (state_q == DROP);
  assign imem_addr  = req_addr_q;
  assign instr_d    = out_instr_q;
  assign pc_d       = out_pc_q;
  assign pc_plus4_d = out_pc4_q;
  assign valid_d    = out_valid_q;

  // Fetch FSM: next state, PC and request address, and where returned data goes.
  always_comb begin
    state_d     = state_q;
    pc_n        = pc_q;
    req_addr_d  = req_addr_q;
    accept_out  = 1'b0;
    accept_skid = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_n = redir_pc;
        end else if (!skid_valid_q) begin
          req_addr_d = pc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            // Returning word belongs to the old path; throw it away.
            pc_n    = redir_pc;
            state_d = IDLE;
          end else begin
            pc_n = req_addr_plus4;
            if (out_free) begin
              // Back-to-back: issue the next word in the same cycle.
              accept_out = 1'b1;
              req_addr_d = req_addr_plus4;
            end else begin
              accept_skid = 1'b1;
              state_d     = IDLE;
            end
          end
        end else if (redirect) begin
          // Address must stay stable until ack, so wait out the old request.
          pc_n    = redir_pc;
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_d = IDLE;
        end
        if (redirect) begin
          pc_n = redir_pc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decode-facing register and skid entry, redirect first, then stall hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_pc4_d    = out_pc4_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (redirect) begin
      out_valid_d  = 1'b0;
      out_instr_d  = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else if (out_valid_q && stall_d) begin
      if (accept_skid) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_rdata;
        skid_pc_d    = req_addr_q;
      end
    end else if (skid_valid_q) begin
      out_valid_d  = 1'b1;
      out_instr_d  = skid_instr_q;
      out_pc_d     = skid_pc_q;
      out_pc4_d    = skid_pc_q + 32'd4;
      skid_valid_d = 1'b0;
    end else if (accept_out) begin
      out_valid_d = 1'b1;
      out_instr_d = imem_rdata;
      out_pc_d    = req_addr_q;
      out_pc4_d   = req_addr_plus4;
    end else begin
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'h0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= 32'h0;
      out_pc4_q    <= 32'd4;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_n;
      req_addr_q   <= req_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_pc4_q    <= out_pc4_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural memory with programmable wait states,
// a scoreboard of words expected at decode, and directed corner cases.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall_d, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;

  // Second instance for the wrap-around reset PC, on a zero-wait memory.
  logic        rst2_n;
  logic        req2;
  logic [31:0] addr2, rdata2, instr2, pc2, pc42;
  logic        valid2;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a ^ 32'h6B3D_0000) + 32'h0000_0100;
  endfunction

  assign imem_rdata = word_at(imem_addr);
  assign rdata2     = word_at(addr2);

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_d(instr_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .stall_d(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(req2), .imem_rdata(rdata2), .instr_d(instr2),
    .pc_d(pc2), .pc_plus4_d(pc42), .valid_d(valid2)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  bit          late_ack = 1'b0;
  bit          drop_pending = 1'b0;
  bit          cont = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] cur_addr = 32'h0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, {31'b0, valid_d}, 32'd0);
    check_val({tag, "_instr"}, instr_d, NOP);
    check_val({tag, "_pc"}, pc_d, 32'h0);
    check_val({tag, "_pc4"}, pc_plus4_d, 32'd4);
    check_val({tag, "_req"}, {31'b0, imem_req}, 32'd0);
  endtask

  // One clock cycle: memory response, scoreboard bookkeeping, then the edge.
  task automatic tick();
    exp_t e;
    bit   pend;
    if (late_ack) begin
      imem_ack = 1'b1;
    end else if (imem_req === 1'b1) begin
      if (wait_cnt >= wait_cfg) begin
        imem_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
    pend = rst_n && imem_req && !imem_ack;
    if (!rst_n) begin
      sb.delete();
      drop_pending = 1'b0;
      cont         = 1'b0;
      wait_cnt     = 0;
      exp_addr     = 32'h0;
    end else begin
      if (cont) begin
        check_val("req_hold", {31'b0, imem_req}, 32'd1);
        check_val("addr_hold", imem_addr, cur_addr);
      end else if (imem_req) begin
        check_val("fetch_addr", imem_addr, exp_addr);
        cur_addr = exp_addr;
      end
      if (valid_d && !stall_d && !redirect) begin
        check_val("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          $display("retire pc=%h instr=%h", pc_d, instr_d);
          check_val("retire_pc", pc_d, e.pc);
          check_val("retire_instr", instr_d, e.instr);
          check_val("retire_pc4", pc_plus4_d, e.pc + 32'd4);
        end
      end else if (!valid_d) begin
        check_val("idle_nop", instr_d, NOP);
      end
      if (redirect) begin
        sb.delete();
        exp_addr = redirect_pc & ~32'h3;
      end
      if (imem_req && imem_ack) begin
        if (redirect || drop_pending) begin
          drop_pending = 1'b0;
        end else begin
          e.pc    = cur_addr;
          e.instr = word_at(cur_addr);
          sb.push_back(e);
          exp_addr = cur_addr + 32'd4;
        end
      end else if (imem_req && redirect) begin
        drop_pending = 1'b1;
      end
      cont = pend;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; stall_d = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; imem_ack = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");

    // Zero-wait streaming from reset.
    rst_n = 1'b1;
    check_val("req_after_reset", {31'b0, imem_req}, 32'd0);
    tick();
    check_val("t1_req", {31'b0, imem_req}, 32'd1);
    check_val("t1_addr0", imem_addr, 32'h0);
    check_val("t1_valid0", {31'b0, valid_d}, 32'd0);
    tick();
    check_val("t1_valid1", {31'b0, valid_d}, 32'd1);
    check_val("t1_pc0", pc_d, 32'h0);
    check_val("t1_addr4", imem_addr, 32'h4);
    tick();
    check_val("t1_pc4", pc_d, 32'h4);
    check_val("t1_instr4", instr_d, word_at(32'h4));
    check_val("t1_addr8", imem_addr, 32'h8);

    // Stall while 0x4 is held: 0x8 lands in the skid.
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t2_hold_pc", pc_d, 32'h4);
      check_val("t2_hold_instr", instr_d, word_at(32'h4));
      check_val("t2_hold_valid", {31'b0, valid_d}, 32'd1);
      check_val("t2_req_off", {31'b0, imem_req}, 32'd0);
    end
    stall_d = 1'b0;
    tick();
    check_val("t2_skid_pc", pc_d, 32'h8);
    check_val("t2_skid_instr", instr_d, word_at(32'h8));
    tick();
    check_val("t2_resume_req", {31'b0, imem_req}, 32'd1);
    check_val("t2_resume_addr", imem_addr, 32'hC);

    // Two-wait memory, redirect during the wait.
    wait_cfg = 2;
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check_val("t3_addr_held", imem_addr, 32'hC);
    check_val("t3_valid_off", {31'b0, valid_d}, 32'd0);
    tick();
    check_val("t3_dropped_valid", {31'b0, valid_d}, 32'd0);
    check_val("t3_idle_req", {31'b0, imem_req}, 32'd0);
    tick();
    check_val("t3_new_req", {31'b0, imem_req}, 32'd1);
    check_val("t3_new_addr", imem_addr, 32'h100);

    // Random traffic through the scoreboard.
    for (int i = 0; i < 80; i++) begin
      wait_cfg    = $urandom_range(0, 2);
      stall_d     = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      tick();
    end

    // Redirect with stall asserted and the skid full.
    redirect = 1'b0; stall_d = 1'b0; wait_cfg = 0;
    for (int i = 0; i < 4; i++) tick();
    check_val("t4_streaming", {31'b0, valid_d}, 32'd1);
    stall_d = 1'b1;
    tick();
    check_val("t4_skid_idle", {31'b0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    check_val("t4_flush_valid", {31'b0, valid_d}, 32'd0);
    check_val("t4_flush_instr", instr_d, NOP);
    stall_d = 1'b0;
    tick();
    check_val("t4_req", {31'b0, imem_req}, 32'd1);
    check_val("t4_addr", imem_addr, 32'h200);
    check_val("t4_skid_cleared", {31'b0, valid_d}, 32'd0);
    tick();
    check_val("t4_first_pc", pc_d, 32'h200);
    check_val("t4_first_valid", {31'b0, valid_d}, 32'd1);

    // Reset in the middle of a wait, followed by a stray ack.
    wait_cfg = 2;
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t6_reset");
    rst_n = 1'b1; late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    check_val("t6_valid", {31'b0, valid_d}, 32'd0);
    check_val("t6_instr", instr_d, NOP);
    check_val("t6_req", {31'b0, imem_req}, 32'd1);
    check_val("t6_addr", imem_addr, 32'h0);
    wait_cfg = 0;
    for (int i = 0; i < 6; i++) tick();

    // Wrap-around PC on the second instance.
    rst2_n = 1'b1;
    check_val("t5_req_off", {31'b0, req2}, 32'd0);
    check_val("t5_rst_pc4", pc42, 32'd4);
    tick();
    check_val("t5_req", {31'b0, req2}, 32'd1);
    check_val("t5_addr_top", addr2, 32'hFFFF_FFFC);
    tick();
    check_val("t5_valid", {31'b0, valid2}, 32'd1);
    check_val("t5_pc", pc2, 32'hFFFF_FFFC);
    check_val("t5_pc4_wrap", pc42, 32'h0);
    check_val("t5_instr", instr2, word_at(32'hFFFF_FFFC));
    check_val("t5_addr_wrap", addr2, 32'h0);
    tick();
    check_val("t5_pc_zero", pc2, 32'h0);
    check_val("t5_pc4_four", pc42, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
